// File: rtl/uart_cmd_responder.sv
// Command responder for the buck-boost controller UART: parses AA/A/DH/DL/C frames, drives the register bus, returns ACK/NAK/read data.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_responder #(
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int unsigned TIMEOUT_CYCLES = 270000
) (
    input  logic        clk_27m,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [6:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [3:0] {
        HUNT, GOT_HDR, GOT_A, GOT_DH, GOT_DL, CHECK, RD_WAIT,
        TX_LOAD, TX_WAIT_HI, TX_WAIT_LO
    } state_t;

    typedef enum logic [1:0] {RESP_ACK, RESP_NAK, RESP_READ} resp_t;

    state_t      state_q, state_d;
    resp_t       resp_q, resp_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        rx_valid_q, rx_error_q;
    logic        byte_stb, err_stb, in_frame, abort, chk_ok, resp_last, timeout_hit;
    logic [7:0]  a_q, dh_q, dl_q, c_q, rh_q, rl_q;
    logic [7:0]  frame_sum, resp_sum;

    assign byte_stb  = rx_valid & ~rx_valid_q;
    assign err_stb   = rx_error & ~rx_error_q;
    assign in_frame  = state_q inside {GOT_HDR, GOT_A, GOT_DH, GOT_DL};
    assign abort     = in_frame && (err_stb || timeout_hit);
    assign frame_sum = a_q + dh_q + dl_q;
    assign resp_sum  = a_q + rh_q + rl_q;
    assign chk_ok    = (frame_sum == c_q);
    assign resp_last = (resp_q == RESP_READ) ? (tx_idx_q == 3'd4) : 1'b1;
    assign busy      = (state_q != HUNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            resp_q     <= RESP_ACK;
            tx_idx_q   <= 3'd0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            tx_idx_q   <= tx_idx_d;
            rx_valid_q <= rx_valid;
            rx_error_q <= rx_error;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        tx_idx_d  = tx_idx_q;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        tx_start  = 1'b0;
        frame_err = 1'b0;
        if (abort) begin
            frame_err = 1'b1;
            state_d   = HUNT;
        end else begin
            case (state_q)
                HUNT:    if (byte_stb && rx_data == HEADER) state_d = GOT_HDR;
                GOT_HDR: if (byte_stb) state_d = GOT_A;
                GOT_A:   if (byte_stb) state_d = GOT_DH;
                GOT_DH:  if (byte_stb) state_d = GOT_DL;
                GOT_DL:  if (byte_stb) state_d = CHECK;
                CHECK: begin
                    tx_idx_d = 3'd0;
                    if (!chk_ok) begin
                        frame_err = 1'b1;
                        resp_d    = RESP_NAK;
                        state_d   = TX_LOAD;
                    end else if (a_q[7]) begin
                        reg_wr  = 1'b1;
                        resp_d  = RESP_ACK;
                        state_d = TX_LOAD;
                    end else begin
                        reg_rd  = 1'b1;
                        resp_d  = RESP_READ;
                        state_d = RD_WAIT;
                    end
                end
                RD_WAIT: state_d = TX_LOAD;
                TX_LOAD: begin
                    tx_start = 1'b1;
                    state_d  = TX_WAIT_HI;
                end
                TX_WAIT_HI: if (tx_busy) state_d = TX_WAIT_LO;
                TX_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (resp_last) begin
                            state_d = HUNT;
                        end else begin
                            tx_idx_d = tx_idx_q + 3'd1;
                            state_d  = TX_LOAD;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Response byte is a pure function of the queued kind and index, so it holds until the index moves.
    always_comb begin
        tx_data = 8'h00;
        if (state_q inside {TX_LOAD, TX_WAIT_HI, TX_WAIT_LO}) begin
            case (resp_q)
                RESP_ACK: tx_data = ACK_BYTE;
                RESP_NAK: tx_data = NAK_BYTE;
                default: begin
                    case (tx_idx_q)
                        3'd0:    tx_data = HEADER;
                        3'd1:    tx_data = a_q;
                        3'd2:    tx_data = rh_q;
                        3'd3:    tx_data = rl_q;
                        default: tx_data = resp_sum;
                    endcase
                end
            endcase
        end
    end

    // Bus address/data only change when a complete frame enters CHECK.
    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= 8'h00;
            dh_q      <= 8'h00;
            dl_q      <= 8'h00;
            c_q       <= 8'h00;
            rh_q      <= 8'h00;
            rl_q      <= 8'h00;
            reg_addr  <= 7'h00;
            reg_wdata <= 16'h0000;
        end else begin
            if (state_q == GOT_HDR && state_d == GOT_A)  a_q  <= rx_data;
            if (state_q == GOT_A   && state_d == GOT_DH) dh_q <= rx_data;
            if (state_q == GOT_DH  && state_d == GOT_DL) dl_q <= rx_data;
            if (state_q == GOT_DL  && state_d == CHECK) begin
                c_q       <= rx_data;
                reg_addr  <= a_q[6:0];
                reg_wdata <= {dh_q, dl_q};
            end
            if (state_q == RD_WAIT) begin
                rh_q <= reg_rdata[15:8];
                rl_q <= reg_rdata[7:0];
            end
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] timeout_cnt_q;

    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_q <= 20'd0;
        end else if (!in_frame || byte_stb) begin
            timeout_cnt_q <= 20'd0;
        end else begin
            timeout_cnt_q <= timeout_cnt_q + 20'd1;
        end
    end

    assign timeout_hit = in_frame && (timeout_cnt_q == TIMEOUT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frame table plus rx_error, stale-level, timeout and reset sequences.
`timescale 1ns/1ps
module tb_uart_cmd_responder;

    localparam int unsigned TB_TIMEOUT = 1000;

    logic        clk_27m = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        frame_err;
    logic        busy;

    uart_cmd_responder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_27m   (clk_27m),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_27m = ~clk_27m;

    typedef struct packed {
        logic [63:0] bytes;     // first byte in the top octet
        logic [3:0]  nbytes;
        logic [15:0] rdata;
        logic        exp_wr;
        logic        exp_rd;
        logic        exp_ferr;
        logic [6:0]  exp_addr;
        logic [15:0] exp_wdata;
        logic [39:0] resp;      // first response byte in the top octet
        logic [2:0]  resp_len;
    } vec_t;

    vec_t vecs [7];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, proto_err = 0;
    logic [6:0]  last_addr;
    logic [15:0] last_wdata;
    logic        prev_start = 1'b0;
    logic [7:0]  tx_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus and transmit monitor
    always @(negedge clk_27m) begin
        if (rst_n) begin
            if (reg_wr) begin
                wr_cnt++;
                last_addr  = reg_addr;
                last_wdata = reg_wdata;
            end
            if (reg_rd) begin
                rd_cnt++;
                last_addr = reg_addr;
            end
            if (frame_err) ferr_cnt++;
            if (tx_start) begin
                tx_log.push_back(tx_data);
                if (prev_start) proto_err++;
            end
            prev_start = tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // UART transmitter model: busy for a few cycles after each start, tx_data must hold meanwhile
    initial begin
        logic [7:0] cap;
        logic       aborted;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk_27m);
            if (rst_n && tx_start) begin
                cap     = tx_data;
                aborted = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk_27m);
                    if (!rst_n) aborted = 1'b1;
                    if (!aborted && tx_data !== cap) proto_err++;
                    if (i == 1) tx_busy = 1'b1;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_27m);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (3) @(posedge clk_27m);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk_27m);
    endtask

    task automatic pulse_rx_error();
        @(posedge clk_27m);
        #1;
        rx_error = 1'b1;
        repeat (2) @(posedge clk_27m);
        #1;
        rx_error = 1'b0;
        repeat (2) @(posedge clk_27m);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_27m);
        while (busy && n < 2000) begin
            @(negedge clk_27m);
            n++;
        end
        check(name, 64'(busy), 64'd0);
        repeat (3) @(negedge clk_27m);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int wr0, rd0, fe0, tx0;
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = ferr_cnt; tx0 = tx_log.size();
        reg_rdata = v.rdata;
        for (int i = 0; i < int'(v.nbytes); i++) send_byte(v.bytes[63-8*i -: 8]);
        wait_idle($sformatf("v%0d_idle", idx));
        check($sformatf("v%0d_wr", idx), 64'(wr_cnt - wr0), 64'(v.exp_wr));
        check($sformatf("v%0d_rd", idx), 64'(rd_cnt - rd0), 64'(v.exp_rd));
        check($sformatf("v%0d_ferr", idx), 64'(fe_delta(fe0)), 64'(v.exp_ferr));
        if (v.exp_wr || v.exp_rd) check($sformatf("v%0d_addr", idx), 64'(last_addr), 64'(v.exp_addr));
        if (v.exp_wr) check($sformatf("v%0d_wdata", idx), 64'(last_wdata), 64'(v.exp_wdata));
        check($sformatf("v%0d_resp_len", idx), 64'(tx_log.size() - tx0), 64'(v.resp_len));
        for (int j = 0; j < int'(v.resp_len); j++) begin
            if (tx0 + j < tx_log.size())
                check($sformatf("v%0d_resp%0d", idx, j), 64'(tx_log[tx0+j]), 64'(v.resp[39-8*j -: 8]));
        end
    endtask

    function automatic int fe_delta(input int base);
        return ferr_cnt - base;
    endfunction

    initial begin
        int wr0, fe0, tx0, n;

        vecs[0] = '{bytes: 64'hAA81_1234_C700_0000, nbytes: 4'd5, rdata: 16'h0000, exp_wr: 1'b1, exp_rd: 1'b0,
                    exp_ferr: 1'b0, exp_addr: 7'h01, exp_wdata: 16'h1234, resp: 40'h06_0000_0000, resp_len: 3'd1};
        vecs[1] = '{bytes: 64'hAA05_0000_0500_0000, nbytes: 4'd5, rdata: 16'hBEEF, exp_wr: 1'b0, exp_rd: 1'b1,
                    exp_ferr: 1'b0, exp_addr: 7'h05, exp_wdata: 16'h0000, resp: 40'hAA05_BEEF_B2, resp_len: 3'd5};
        vecs[2] = '{bytes: 64'hAA81_1234_0000_0000, nbytes: 4'd5, rdata: 16'h0000, exp_wr: 1'b0, exp_rd: 1'b0,
                    exp_ferr: 1'b1, exp_addr: 7'h00, exp_wdata: 16'h0000, resp: 40'h15_0000_0000, resp_len: 3'd1};
        vecs[3] = '{bytes: 64'h00FF_55AA_82AB_CDFA, nbytes: 4'd8, rdata: 16'h0000, exp_wr: 1'b1, exp_rd: 1'b0,
                    exp_ferr: 1'b0, exp_addr: 7'h02, exp_wdata: 16'hABCD, resp: 40'h06_0000_0000, resp_len: 3'd1};
        vecs[4] = '{bytes: 64'hAA7F_0000_7F00_0000, nbytes: 4'd5, rdata: 16'h0181, exp_wr: 1'b0, exp_rd: 1'b1,
                    exp_ferr: 1'b0, exp_addr: 7'h7F, exp_wdata: 16'h0000, resp: 40'hAA7F_0181_01, resp_len: 3'd5};
        vecs[5] = '{bytes: 64'hAAFF_FFFF_FD00_0000, nbytes: 4'd5, rdata: 16'h0000, exp_wr: 1'b1, exp_rd: 1'b0,
                    exp_ferr: 1'b0, exp_addr: 7'h7F, exp_wdata: 16'hFFFF, resp: 40'h06_0000_0000, resp_len: 3'd1};
        vecs[6] = '{bytes: 64'hAA10_1234_5600_0000, nbytes: 4'd5, rdata: 16'h0000, exp_wr: 1'b0, exp_rd: 1'b1,
                    exp_ferr: 1'b0, exp_addr: 7'h10, exp_wdata: 16'h0000, resp: 40'hAA10_0000_10, resp_len: 3'd5};

        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        reg_rdata = 16'h0000;
        repeat (3) @(negedge clk_27m);
        check("reset_outputs", {28'd0, tx_data, tx_start, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err, busy}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_27m);

        for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

        // rx_error mid-frame aborts silently; rx_error in HUNT is ignored
        wr0 = wr_cnt; fe0 = ferr_cnt; tx0 = tx_log.size();
        send_byte(8'hAA);
        send_byte(8'h81);
        pulse_rx_error();
        wait_idle("rxerr_idle");
        check("rxerr_ferr", 64'(ferr_cnt - fe0), 64'd1);
        check("rxerr_no_resp", 64'(tx_log.size() - tx0), 64'd0);
        fe0 = ferr_cnt;
        pulse_rx_error();
        check("rxerr_hunt_ignored", 64'(ferr_cnt - fe0), 64'd0);
        apply_vec(10, vecs[0]);

        // HEADER level held across the end of a response must not start a frame
        reg_rdata = vecs[1].rdata;
        tx0 = tx_log.size();
        for (int i = 0; i < 5; i++) send_byte(vecs[1].bytes[63-8*i -: 8]);
        @(posedge clk_27m);
        #1;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        wait_idle("stale_idle");
        repeat (10) @(negedge clk_27m);
        check("stale_not_accepted", 64'(busy), 64'd0);
        check("stale_resp_len", 64'(tx_log.size() - tx0), 64'd5);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk_27m);

`ifdef UART_CMD_TIMEOUT_EN
        fe0 = ferr_cnt; tx0 = tx_log.size();
        send_byte(8'hAA);
        send_byte(8'h81);
        n = 0;
        while (ferr_cnt == fe0 && n < 3 * TB_TIMEOUT) begin
            @(negedge clk_27m);
            n++;
        end
        repeat (3) @(negedge clk_27m);
        check("timeout_ferr", 64'(ferr_cnt - fe0), 64'd1);
        check("timeout_hunt", 64'(busy), 64'd0);
        check("timeout_no_resp", 64'(tx_log.size() - tx0), 64'd0);
        apply_vec(11, vecs[1]);
`else
        wr0 = wr_cnt; fe0 = ferr_cnt;
        send_byte(8'hAA);
        send_byte(8'h81);
        n = 0;
        while (n < 1500) begin
            @(negedge clk_27m);
            n++;
        end
        check("partial_waits_busy", 64'(busy), 64'd1);
        check("partial_no_ferr", 64'(ferr_cnt - fe0), 64'd0);
        tx0 = tx_log.size();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hC7);
        wait_idle("partial_idle");
        check("partial_wr", 64'(wr_cnt - wr0), 64'd1);
        check("partial_wdata", 64'(last_wdata), 64'h1234);
        check("partial_ack_len", 64'(tx_log.size() - tx0), 64'd1);
`endif

        // Reset during the third byte of a read response
        reg_rdata = 16'hBEEF;
        tx0 = tx_log.size();
        for (int i = 0; i < 5; i++) send_byte(vecs[1].bytes[63-8*i -: 8]);
        n = 0;
        while (tx_log.size() < tx0 + 3 && n < 500) begin
            @(negedge clk_27m);
            n++;
        end
        check("rst_reached_byte3", 64'(tx_log.size() - tx0), 64'd3);
        @(posedge clk_27m);
        #1;
        rst_n = 1'b0;
        @(negedge clk_27m);
        check("rst_mid_outputs", {28'd0, tx_data, tx_start, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err, busy}, 64'd0);
        @(negedge clk_27m);
        rst_n = 1'b1;
        repeat (60) @(negedge clk_27m);
        check("rst_no_more_start", 64'(tx_log.size() - tx0), 64'd3);
        check("rst_idle", 64'(busy), 64'd0);
        apply_vec(12, vecs[1]);

        check("protocol", 64'(proto_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
